led_frame_sched: RTL and testbench

- Frame readout scheduler in the clk_sys domain, between the LED frame RAM and the LED driver shift interface.
- On a send request from the SPI receive path, it reads n_LEDS bytes from frame RAM and streams them to the driver over a valid/ready handshake.
- After the last byte it pulses the driver latch, then returns to idle.
- It synchronises the cross-domain send request and queues one request that arrives while a frame is in flight.

---
 rtl/led_pkg.sv | 17 +
 rtl/led_sync_edge.sv | 25 ++
 rtl/led_frame_sched.sv | 152 +++++++++++++++
 tb/tb_led_frame_sched.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and constants for the LED frame scheduler
package led_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PUSH, LATCH} state_t;

  localparam logic [7:0] SETTING_BRIGHTNESS = 8'h01;
  localparam int N_LEDS_DEFAULT     = 320;
  localparam int ADDR_WIDTH_DEFAULT = 9;

  // Gamma 2.0 table, out = round(in^2 / 255); constant contents, maps to a ROM
  function automatic logic [7:0] gamma_lut(input logic [7:0] x);
    logic [15:0] sq;
    sq = 16'(x) * 16'(x) + 16'd127;
    return 8'(sq / 16'd255);
  endfunction

endpackage

// File: rtl/led_sync_edge.sv
// rtl/led_sync_edge.sv - 2-flop synchroniser with registered rising-edge strobe
module led_sync_edge (
  input  logic clk_sys,
  input  logic n_rst,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk_sys or negedge n_rst) begin
    if (!n_rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/led_frame_sched.sv
// rtl/led_frame_sched.sv - frame RAM readout scheduler; LED_FRAME_SCHED_GAMMA_EN adds gamma ROM stage
module led_frame_sched
  import led_pkg::*;
#(
  parameter int n_LEDS       = N_LEDS_DEFAULT,
  parameter int addr_width   = ADDR_WIDTH_DEFAULT,
  parameter int data_width   = 8,
  parameter int latch_cycles = 4
) (
  input  logic                  clk_sys,
  input  logic                  n_rst,
  input  logic                  send,
  input  logic [addr_width-1:0] start_addr,
  input  logic [15:0]           settings,
  output logic                  rd_en,
  output logic [addr_width-1:0] raddr,
  input  logic [data_width-1:0] rdata,
  output logic [data_width-1:0] drv_data,
  output logic                  drv_valid,
  input  logic                  drv_ready,
  output logic                  drv_latch,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IW = (n_LEDS > 1) ? $clog2(n_LEDS) : 1;
  localparam int LW = (latch_cycles > 1) ? $clog2(latch_cycles) : 1;
  localparam int PW = data_width + 9;

  state_t                state;
  logic                  start_evt;
  logic                  pending;
  logic [addr_width-1:0] base;
  logic [IW-1:0]         index;
  logic [IW-1:0]         index_nx;
  logic [LW-1:0]         lcnt;
  logic [7:0]            bright;
  logic [7:0]            bright_q;
  logic [PW-1:0]         prod;
  logic [data_width-1:0] scaled;
  logic                  last_byte;
`ifdef LED_FRAME_SCHED_GAMMA_EN
  logic [data_width-1:0] scaled_q;
  logic                  wait_hold;
`endif

  led_sync_edge u_send_sync (
    .clk_sys (clk_sys),
    .n_rst   (n_rst),
    .din     (send),
    .rise    (start_evt)
  );

  // Live brightness follows the settings bus; bright_q freezes it per frame
  always_ff @(posedge clk_sys or negedge n_rst) begin
    if (!n_rst) begin
      bright <= 8'hFF;
    end else if (settings[15:8] == SETTING_BRIGHTNESS) begin
      bright <= settings[7:0];
    end
  end

  assign prod      = PW'(rdata) * PW'({1'b0, bright_q} + 9'd1);
  assign scaled    = data_width'(prod >> 8);
  assign index_nx  = index + IW'(1);
  assign last_byte = (index == IW'(n_LEDS - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk_sys or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      pending    <= 1'b0;
      base       <= '0;
      index      <= '0;
      lcnt       <= '0;
      bright_q   <= 8'hFF;
      rd_en      <= 1'b0;
      raddr      <= '0;
      drv_data   <= '0;
      drv_valid  <= 1'b0;
      drv_latch  <= 1'b0;
      frame_done <= 1'b0;
`ifdef LED_FRAME_SCHED_GAMMA_EN
      scaled_q   <= '0;
      wait_hold  <= 1'b0;
`endif
    end else begin
      rd_en      <= 1'b0;
      frame_done <= 1'b0;
      if (state != IDLE && start_evt) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (start_evt || pending) begin
            base     <= start_addr;
            index    <= '0;
            pending  <= 1'b0;
            bright_q <= bright;
            rd_en    <= 1'b1;
            raddr    <= start_addr;
            state    <= FETCH;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
`ifdef LED_FRAME_SCHED_GAMMA_EN
          if (!wait_hold) begin
            scaled_q  <= scaled;
            wait_hold <= 1'b1;
          end else begin
            wait_hold <= 1'b0;
            drv_data  <= data_width'(gamma_lut(8'(scaled_q)));
            drv_valid <= 1'b1;
            state     <= PUSH;
          end
`else
          drv_data  <= scaled;
          drv_valid <= 1'b1;
          state     <= PUSH;
`endif
        end
        PUSH: begin
          if (drv_ready) begin
            drv_valid <= 1'b0;
            if (last_byte) begin
              drv_latch  <= 1'b1;
              lcnt       <= '0;
              frame_done <= (latch_cycles == 1);
              state      <= LATCH;
            end else begin
              index <= index_nx;
              rd_en <= 1'b1;
              raddr <= base + addr_width'(index_nx);
              state <= FETCH;
            end
          end
        end
        LATCH: begin
          // frame_done is raised one cycle early so it lands on the final latch cycle
          if (lcnt == LW'(latch_cycles - 1)) begin
            drv_latch <= 1'b0;
            state     <= IDLE;
          end else begin
            lcnt       <= lcnt + LW'(1);
            frame_done <= (lcnt == LW'(latch_cycles - 2));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_sched.sv
// tb/tb_led_frame_sched.sv - self-checking bench for led_frame_sched
module tb_led_frame_sched;

  localparam int NL = 4;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int LC = 4;

  logic          clk_sys = 1'b0;
  logic          n_rst = 1'b0;
  logic          send = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [15:0]   settings = '0;
  logic          rd_en;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] drv_data;
  logic          drv_valid;
  logic          drv_ready;
  logic          drv_latch;
  logic          busy;
  logic          frame_done;

  led_frame_sched #(
    .n_LEDS(NL), .addr_width(AW), .data_width(DW), .latch_cycles(LC)
  ) dut (
    .clk_sys(clk_sys), .n_rst(n_rst), .send(send), .start_addr(start_addr),
    .settings(settings), .rd_en(rd_en), .raddr(raddr), .rdata(rdata),
    .drv_data(drv_data), .drv_valid(drv_valid), .drv_ready(drv_ready),
    .drv_latch(drv_latch), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0] ram [512];
  always @(posedge clk_sys) if (rd_en) rdata <= ram[raddr];

  int n_vec = 0;
  int n_err = 0;
  int model_bright = 255;
  int frames = 0;
  int cycle = 0;
  int last_acc = -10;
  int ready_mode = 0;
  logic [7:0] exp_q[$];
  int         exp_a[$];
  logic [7:0] acc_log[$];
  int         addr_log[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] scale(input logic [7:0] v, input int b);
    return 8'((int'(v) * (b + 1)) >> 8);
  endfunction

  task automatic expect_frame(input int b);
    for (int i = 0; i < NL; i++) begin
      exp_a.push_back((b + i) % 512);
      exp_q.push_back(scale(ram[(b + i) % 512], model_bright));
    end
  endtask

  task automatic set_settings(input logic [15:0] s);
    settings = s;
    if (s[15:8] == 8'h01) model_bright = int'(s[7:0]);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #2;
    end
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 20 && !busy; i++) tick(1);
    chk("start_timeout", int'(busy), 1);
  endtask

  task automatic wait_frames(input int f0, input int n);
    for (int i = 0; i < 600 && (frames - f0) < n; i++) tick(1);
    chk("done_timeout", frames - f0, n);
  endtask

  task automatic frame(input int b);
    int f0;
    start_addr = AW'(b);
    expect_frame(b);
    f0 = frames;
    send = 1'b1;
    wait_busy();
    send = 1'b0;
    wait_frames(f0, 1);
    tick(3);
  endtask

  initial begin
    forever begin
      @(posedge clk_sys);
      #2;
      if (ready_mode == 2) drv_ready = 1'($urandom_range(0, 1));
      else drv_ready = (ready_mode == 1);
    end
  end

  // Scoreboard: addresses, bytes, handshake stability, latch shape
  logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [7:0] pd = '0;
  int         run = 0;
  always @(negedge clk_sys) begin
    if (!n_rst) begin
      pv = 1'b0; pl = 1'b0; run = 0;
    end else begin
      cycle++;
      if (rd_en) begin
        addr_log.push_back(int'(raddr));
        if (exp_a.size() == 0) chk("extra_read", 1, 0);
        else chk("raddr", int'(raddr), exp_a.pop_front());
      end
      if (pv && !pr) begin
        chk("hold_valid", int'(drv_valid), 1);
        chk("hold_data", int'(drv_data), int'(pd));
      end
      if (drv_valid && drv_ready) begin
        acc_log.push_back(drv_data);
        last_acc = cycle;
        if (exp_q.size() == 0) chk("extra_byte", 1, 0);
        else chk("byte", int'(drv_data), int'(exp_q.pop_front()));
      end
      if (drv_latch) begin
        if (!pl) chk("latch_latency", cycle - last_acc, 1);
        run = pl ? run + 1 : 1;
      end else if (pl) begin
        chk("latch_len", run, LC);
      end
      if (frame_done) begin
        frames++;
        chk("done_position", drv_latch ? run : 0, LC);
      end
      pv = drv_valid; pr = drv_ready; pd = drv_data; pl = drv_latch;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, f0, seen;
    for (int i = 0; i < 512; i++) ram[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 4; i++) ram[i] = 8'(i + 1);

    #12;
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_valid", int'(drv_valid), 0);
    chk("rst_latch", int'(drv_latch), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_data", int'(drv_data), 0);
    @(posedge clk_sys); #2;
    n_rst = 1'b1;
    tick(3);

    // Basic frame with start latency
    ready_mode = 1;
    start_addr = '0;
    expect_frame(0);
    acc_log.delete();
    f0 = frames;
    tick(1);
    send = 1'b1;
    k = 0;
    do begin
      @(negedge clk_sys);
      k++;
    end while (!rd_en && k < 20);
    chk("first_rd_latency", k, 5);
    wait_frames(f0, 1);
    send = 1'b0;
    tick(3);
    chk("t1_count", acc_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_literal", int'(acc_log[i]), i + 1);

    // Address wrap
    ram[510] = 8'h11; ram[511] = 8'h22; ram[0] = 8'h33; ram[1] = 8'h44;
    addr_log.delete();
    frame(510);
    chk("wrap_a0", addr_log[0], 510);
    chk("wrap_a1", addr_log[1], 511);
    chk("wrap_a2", addr_log[2], 0);
    chk("wrap_a3", addr_log[3], 1);

    // Random backpressure
    ready_mode = 2;
    frame(100);
    frame(200);
    frame(300);
    ready_mode = 1;
    tick(2);

    // Brightness sampled at frame start
    set_settings(16'h0180);
    for (int i = 20; i < 24; i++) ram[i] = 8'hFF;
    tick(2);
    acc_log.delete();
    start_addr = 9'd20;
    expect_frame(20);
    f0 = frames;
    send = 1'b1;
    for (int i = 0; i < 40 && acc_log.size() == 0; i++) tick(1);
    set_settings(16'h0110);
    send = 1'b0;
    wait_frames(f0, 1);
    tick(2);
    for (int i = 0; i < 4; i++) chk("bright_literal", int'(acc_log[i]), 8'h80);
    set_settings(16'h01FF);
    tick(3);

    // Queued requests: two during the frame, one in the frame_done cycle
    start_addr = 9'd40;
    expect_frame(40);
    expect_frame(40);
    f0 = frames;
    send = 1'b1;
    wait_busy();
    send = 1'b0; tick(2);
    send = 1'b1; tick(2);
    send = 1'b0; tick(2);
    send = 1'b1; tick(2);
    send = 1'b0;
    for (int i = 0; i < 40 && !drv_latch; i++) tick(1);
    send = 1'b1;
    k = 0;
    do begin
      @(negedge clk_sys);
      k++;
    end while (!frame_done && k < 20);
    chk("done_seen", int'(frame_done), 1);
    @(negedge clk_sys);
    chk("reidle_busy", int'(busy), 0);
    chk("reidle_rd", int'(rd_en), 0);
    @(negedge clk_sys);
    chk("restart_rd", int'(rd_en), 1);
    #3;
    send = 1'b0;
    wait_frames(f0, 2);
    tick(20);
    chk("queued_frames", frames - f0, 2);
    chk("queued_left", exp_q.size(), 0);

    // Reset during PUSH with a pending request
    ready_mode = 0;
    start_addr = 9'd60;
    expect_frame(60);
    send = 1'b1;
    for (int i = 0; i < 20 && !drv_valid; i++) tick(1);
    chk("push_reached", int'(drv_valid), 1);
    send = 1'b0; tick(2);
    send = 1'b1; tick(2);
    send = 1'b0; tick(3);
    @(negedge clk_sys); #2;
    n_rst = 1'b0;
    #1;
    chk("arst_valid", int'(drv_valid), 0);
    chk("arst_latch", int'(drv_latch), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_rd", int'(rd_en), 0);
    exp_q.delete();
    exp_a.delete();
    f0 = frames;
    tick(3);
    n_rst = 1'b1;
    ready_mode = 1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (busy || rd_en) seen = 1;
    end
    chk("idle_after_rst", seen, 0);
    chk("no_done_after_rst", frames - f0, 0);
    frame(70);
    chk("post_rst_frame", frames - f0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
